// File: rtl/run_length_tx_pkg.sv
// Shared definitions for the run-length transmitter and its run tracker.
package run_length_tx_pkg;

   // Default detector threshold, shared with the detector bench.
   localparam int unsigned DEF_DETECT_N = 4;

   // Token sequencer states.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

endpackage

// File: rtl/run_length_tx_run_tracker.sv
// Run tracker: counts consecutive equal valid bits on a serial line (saturating
// at DETECT_N) and predicts when a DETECT_N-run detector must assert.
// w / w_valid are the values being loaded into the serial-line register this
// edge, so run_cnt and z_expect line up with the registered line itself.
module run_tracker
   import run_length_tx_pkg::*;
#(
   parameter int unsigned DETECT_N = DEF_DETECT_N,
   parameter int unsigned RUN_W    = $clog2(DETECT_N + 1)
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             w,
   input  logic             w_valid,
   output logic [RUN_W-1:0] run_cnt,
   output logic             z_expect
);

   logic             w_q;
   logic             w_valid_q;
   logic [RUN_W-1:0] cnt_d;

   // Next count: extend a matching gap-free run, restart on change, clear on gap.
   always_comb begin
      cnt_d = '0;
      if (w_valid) begin
         if (w_valid_q && (w == w_q)) begin
            cnt_d = (run_cnt == RUN_W'(DETECT_N)) ? run_cnt : run_cnt + RUN_W'(1);
         end else begin
            cnt_d = RUN_W'(1);
         end
      end
   end

   // Local copy of the line plus the run count register.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         w_q       <= 1'b0;
         w_valid_q <= 1'b0;
         run_cnt   <= '0;
      end else begin
         w_q       <= w;
         w_valid_q <= w_valid;
         run_cnt   <= cnt_d;
      end
   end

   assign z_expect = (run_cnt == RUN_W'(DETECT_N)) && w_valid_q;

endmodule

// File: rtl/run_length_tx.sv
// Serial run-length transmitter: turns (bit, length) tokens into runs of
// identical bits on w, with a registered detector-output prediction.
module run_length_tx
   import run_length_tx_pkg::*;
#(
   parameter int unsigned LEN_W    = 4,
   parameter int unsigned DETECT_N = DEF_DETECT_N,
   parameter int unsigned RUN_W    = $clog2(DETECT_N + 1)
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic [LEN_W-1:0] in_len,
   output logic             in_ready,
   output logic             w,
   output logic             w_valid,
   output logic             run_done,
   output logic             z_expect
);

   state_t           state, state_d;
   logic [LEN_W-1:0] remaining, remaining_d;
   logic             w_d, w_valid_d;
   logic             accept;
   logic             last_bit;
   logic [RUN_W-1:0] run_cnt;
   logic             z_trk;

   assign last_bit = (state == ST_EMIT) && (remaining == '0);
   assign in_ready = (state == ST_IDLE) || last_bit;
   assign accept   = in_valid && in_ready;
   assign run_done = last_bit;

   // Next-state / next-line logic; a token taken on the last bit reloads with no bubble.
   always_comb begin
      state_d     = state;
      remaining_d = remaining;
      w_d         = w;
      w_valid_d   = w_valid;
      case (state)
         ST_IDLE: begin
            w_valid_d = 1'b0;
            if (accept && (in_len != '0)) begin
               w_d         = in_bit;
               w_valid_d   = 1'b1;
               remaining_d = in_len - LEN_W'(1);
               state_d     = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (remaining != '0) begin
               remaining_d = remaining - LEN_W'(1);
            end else if (accept && (in_len != '0)) begin
               w_d         = in_bit;
               w_valid_d   = 1'b1;
               remaining_d = in_len - LEN_W'(1);
            end else begin
               w_valid_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            w_valid_d = 1'b0;
         end
      endcase
   end

   // Sequencer state and serial-line registers.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         remaining <= '0;
         w         <= 1'b0;
         w_valid   <= 1'b0;
      end else begin
         state     <= state_d;
         remaining <= remaining_d;
         w         <= w_d;
         w_valid   <= w_valid_d;
      end
   end

   run_tracker #(
      .DETECT_N (DETECT_N),
      .RUN_W    (RUN_W)
   ) u_run_tracker (
      .clock    (clock),
      .rst      (rst),
      .w        (w_d),
      .w_valid  (w_valid_d),
      .run_cnt  (run_cnt),
      .z_expect (z_trk)
   );

   // Both tracker outputs agree by construction; combining them keeps the count in use here.
   assign z_expect = z_trk && (run_cnt == RUN_W'(DETECT_N));

endmodule

// File: tb/tb_run_length_tx.sv
// Directed bench for run_length_tx. Inputs change and outputs are sampled on
// the falling edge; observed vector is {in_ready, w_valid, w, run_done, z_expect}.
module tb_run_length_tx;

   logic       clock;
   logic       rst;
   logic       in_valid;
   logic       in_bit;
   logic [3:0] in_len;
   logic       in_ready;
   logic       w;
   logic       w_valid;
   logic       run_done;
   logic       z_expect;

   int checks   = 0;
   int failures = 0;

   run_length_tx #(
      .LEN_W    (4),
      .DETECT_N (4)
   ) dut (
      .clock    (clock),
      .rst      (rst),
      .in_valid (in_valid),
      .in_bit   (in_bit),
      .in_len   (in_len),
      .in_ready (in_ready),
      .w        (w),
      .w_valid  (w_valid),
      .run_done (run_done),
      .z_expect (z_expect)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [4:0] obs();
      return {in_ready, w_valid, w, run_done, z_expect};
   endfunction

   task automatic drive(input logic v, input logic b, input logic [3:0] l);
      in_valid = v;
      in_bit   = b;
      in_len   = l;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 4'd4);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clock);
         checks++;
         if (obs() !== 5'b10000) begin
            failures++;
            $display("FAIL reset cycle %0d: rdy/wv/w/rd/z got %b want %b", c, obs(), 5'b10000);
         end
      end
      drive(1'b0, 1'b0, 4'd0);
      rst = 1'b1;
      @(negedge clock);
      checks++;
      if (obs() !== 5'b10000) begin
         failures++;
         $display("FAIL reset_release: rdy/wv/w/rd/z got %b want %b", obs(), 5'b10000);
      end
   endtask

   task automatic test_single();
      logic [4:0] exp [1:5];
      exp = '{5'b01100, 5'b01100, 5'b01100, 5'b11111, 5'b10100};
      drive(1'b1, 1'b1, 4'd4);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clock);
         if (c == 1) drive(1'b0, 1'b0, 4'd0);
         checks++;
         if (obs() !== exp[c]) begin
            failures++;
            $display("FAIL single cycle %0d: rdy/wv/w/rd/z got %b want %b", c, obs(), exp[c]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp [1:6];
      exp = '{5'b01100, 5'b11110, 5'b01100, 5'b01101, 5'b11111, 5'b10100};
      drive(1'b1, 1'b1, 4'd2);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clock);
         if (c == 1) drive(1'b1, 1'b1, 4'd3);
         if (c == 5) drive(1'b0, 1'b0, 4'd0);
         checks++;
         if (obs() !== exp[c]) begin
            failures++;
            $display("FAIL back_to_back cycle %0d: rdy/wv/w/rd/z got %b want %b", c, obs(), exp[c]);
         end
      end
   endtask

   task automatic test_alternating();
      logic [4:0] exp [1:10];
      exp = '{5'b01100, 5'b01100, 5'b11110, 5'b01000, 5'b01000,
              5'b11010, 5'b01100, 5'b01100, 5'b11110, 5'b10100};
      drive(1'b1, 1'b1, 4'd3);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         if (c == 1) drive(1'b1, 1'b0, 4'd3);
         if (c == 4) drive(1'b1, 1'b1, 4'd3);
         if (c == 9) drive(1'b0, 1'b0, 4'd0);
         checks++;
         if (obs() !== exp[c]) begin
            failures++;
            $display("FAIL alternating cycle %0d: rdy/wv/w/rd/z got %b want %b", c, obs(), exp[c]);
         end
      end
   endtask

   task automatic test_zero_len();
      logic [4:0] exp [1:6];
      // (1,0) in IDLE: consumed, line stays idle holding w=1.
      drive(1'b1, 1'b1, 4'd0);
      for (int c = 1; c <= 2; c++) begin
         @(negedge clock);
         if (c == 1) drive(1'b0, 1'b0, 4'd0);
         checks++;
         if (obs() !== 5'b10100) begin
            failures++;
            $display("FAIL zero_len_idle cycle %0d: rdy/wv/w/rd/z got %b want %b", c, obs(), 5'b10100);
         end
      end
      // (1,4) followed by (0,0) taken on its last bit.
      exp = '{5'b01100, 5'b01100, 5'b01100, 5'b11111, 5'b10100, 5'b10100};
      drive(1'b1, 1'b1, 4'd4);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clock);
         if (c == 1) drive(1'b1, 1'b0, 4'd0);
         if (c == 5) drive(1'b0, 1'b0, 4'd0);
         checks++;
         if (obs() !== exp[c]) begin
            failures++;
            $display("FAIL zero_len_tail cycle %0d: rdy/wv/w/rd/z got %b want %b", c, obs(), exp[c]);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [4:0] exp [1:6];
      logic [4:0] exp2 [1:5];
      exp  = '{5'b01100, 5'b01100, 5'b01100, 5'b01101, 5'b01101, 5'b01101};
      exp2 = '{5'b01000, 5'b01000, 5'b01000, 5'b11011, 5'b10000};
      drive(1'b1, 1'b1, 4'd15);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clock);
         if (c == 1) drive(1'b0, 1'b0, 4'd0);
         checks++;
         if (obs() !== exp[c]) begin
            failures++;
            $display("FAIL long_run cycle %0d: rdy/wv/w/rd/z got %b want %b", c, obs(), exp[c]);
         end
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (obs() !== 5'b10000) begin
         failures++;
         $display("FAIL async_reset: rdy/wv/w/rd/z got %b want %b", obs(), 5'b10000);
      end
      @(negedge clock);
      checks++;
      if (obs() !== 5'b10000) begin
         failures++;
         $display("FAIL reset_held: rdy/wv/w/rd/z got %b want %b", obs(), 5'b10000);
      end
      rst = 1'b1;
      drive(1'b1, 1'b0, 4'd4);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clock);
         if (c == 1) drive(1'b0, 1'b0, 4'd0);
         checks++;
         if (obs() !== exp2[c]) begin
            failures++;
            $display("FAIL after_reset cycle %0d: rdy/wv/w/rd/z got %b want %b", c, obs(), exp2[c]);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, 1'b0, 4'd0);
      test_reset();
      test_single();
      test_back_to_back();
      test_alternating();
      test_zero_len();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within 100000 time units");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/run_length_tx.md
Name: run_length_tx

Overview:
- Serial run-length transmitter: accepts (bit value, run length) tokens over a valid/ready handshake and emits each as a run of identical bits on a serial line.
- This is the sending end of the consecutive-equal-bit detector interface. Its serial output drives a run detector's data input in block-level and system benches.
- Also produces a registered prediction of when a DETECT_N-run detector must assert its output, for scoreboard comparison.

Parameters:
- LEN_W, 4, width of the run-length field. Legal lengths are 0..2^LEN_W-1.
- DETECT_N, 4, run length at which the downstream detector asserts. Sets the z_expect threshold.
- RUN_W, $clog2(DETECT_N+1), width of the internal saturating run counter.

Ports:
- clock  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  token valid.
- in_bit  input  1  bit value of the run.
- in_len  input  LEN_W  run length in cycles.
- in_ready  output  1  token accept; a handshake occurs when in_valid && in_ready at a rising clock edge.
- w  output  1  serial data to the detector.
- w_valid  output  1  w carries a run bit this cycle.
- run_done  output  1  one-cycle pulse on the last bit of each run.
- z_expect  output  1  detector output prediction.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, w=0, w_valid=0, run_done=0, z_expect=0, remaining=0, run_cnt=0. Reset applies immediately, mid-run included; the token in flight is lost.
- in_ready is combinational: (state==IDLE) || (state==EMIT && remaining==0). It is 1 during reset release.
- States:
  - IDLE: w_valid=0 and w holds its last value.
    - Handshake with in_len!=0: at the edge, w<=in_bit, w_valid<=1, remaining<=in_len-1, go to EMIT.
    - Handshake with in_len==0: token consumed and discarded; stay in IDLE.
  - EMIT, remaining!=0: remaining decrements each cycle; w and w_valid are held.
  - EMIT, remaining==0: current cycle is the last bit of the run; run_done=1.
    - Handshake with in_len!=0: reload seamlessly, with no bubble. Next cycle w=in_bit, w_valid=1.
    - Handshake with in_len==0, or no handshake: next cycle w_valid=0; go to IDLE.
- Latency: first bit appears one cycle after the accepting edge. A run of length L occupies exactly L contiguous cycles with w_valid=1.
- Run tracking, registered, updated with w:
  - Each cycle w_valid=1: if the previous cycle also had w_valid=1 and the same w, run_cnt <= min(run_cnt+1, DETECT_N); otherwise run_cnt <= 1.
  - A cycle with w_valid=0 clears run_cnt to 0.
  - A run counts across token boundaries when bits match and there is no gap.
- z_expect = (run_cnt==DETECT_N) && w_valid. It is high on the DETECT_N-th consecutive equal bit and on every following equal bit (overlapping runs).
- Arithmetic: remaining is LEN_W bits wide and never wraps below 0, because decrement happens only when remaining!=0.
- in_bit and in_len are sampled only at a handshake. Changes while in_ready=0 are ignored.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=1'b0, ST_EMIT=1'b1;
  - DETECT_N default of 4, shared with the detector bench.
- One sub-module, run_tracker: inputs clock, rst, w, w_valid; outputs run_cnt and z_expect. It is reusable by any detector scoreboard.
- Token sequencing (state, remaining, handshake) stays in the top module.

Test Plan:
1. Reset: hold rst=0 with in_valid=1 -> w=0, w_valid=0, run_done=0, z_expect=0, no token consumed. After release, in_ready=1.
2. Single token (1,4) -> w=1/w_valid=1 for cycles 1..4 after accept. run_done and z_expect both high only on cycle 4. w_valid=0 on cycle 5.
3. Back-to-back (1,2) then (1,3), with in_valid held high:
   - 5 contiguous 1s with no gap;
   - in_ready high only on cycles 2 and 5;
   - z_expect high on cycles 4 and 5;
   - run_done high on cycles 2 and 5.
4. Tokens (1,3),(0,3),(1,3) back-to-back -> 9 contiguous bits 111000111, run_cnt restarts at each change, z_expect never asserts.
5. Zero-length token (1,0) in IDLE -> accepted, w_valid stays 0. Token (0,0) sent on the last bit of a (1,4) run -> w_valid drops the next cycle.
6. Token (1,15) with rst pulsed low mid-cycle after 6 bits -> w, w_valid, z_expect go to 0 asynchronously before the next edge. After release, token (0,4) is emitted normally with z_expect on its 4th bit.
